// File: rtl/xor_descrambler32_pkg.sv
// Shared types and constants for the 32-bit XOR descrambler.
package xor_descrambler32_pkg;

  // Packet-level control states.
  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StActive = 2'd1,
    StDrain  = 2'd2
  } state_e;

  // Galois feedback mask for x^32 + x^22 + x^2 + x + 1.
  localparam logic [31:0] DefaultPoly = 32'h80200003;

  // An all-zero LFSR would lock up, so a zero seed is replaced by this value.
  localparam logic [31:0] ZeroSeedSub = 32'h00000001;

  // LFSR value while in reset.
  localparam logic [31:0] LfsrResetVal = 32'h00000001;

  // Substitute the lock-up-free value for a zero seed.
  function automatic logic [31:0] fix_seed(input logic [31:0] s);
    return (s == 32'h0) ? ZeroSeedSub : s;
  endfunction

endpackage

// File: rtl/lfsr32_galois.sv
// 32-bit Galois LFSR keystream generator: seed load has priority over step.
module lfsr32_galois
  import xor_descrambler32_pkg::*;
#(
  parameter logic [31:0] POLY = DefaultPoly
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        load_i,
  input  logic [31:0] seed_i,
  input  logic        step_i,
  output logic [31:0] state_o
);

  logic [31:0] state_q, state_d;

  // Next state: load seed, advance one Galois step, or hold.
  always_comb begin
    state_d = state_q;
    if (load_i) begin
      state_d = seed_i;
    end else if (step_i) begin
      state_d = (state_q >> 1) ^ (state_q[0] ? POLY : 32'h0);
    end
  end

  // LFSR state register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= LfsrResetVal;
    end else begin
      state_q <= state_d;
    end
  end

  assign state_o = state_q;

endmodule

// File: rtl/xor_descrambler32.sv
// Streaming 32-bit XOR descrambler with a single output register and packet control.
module xor_descrambler32
  import xor_descrambler32_pkg::*;
#(
  parameter logic [31:0] POLY  = DefaultPoly,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             seed_load,
  input  logic [31:0]      seed,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_data,
  output logic             out_last,
  output logic [CNT_W-1:0] word_cnt,
  output logic             seed_err
);

  state_e             state_q, state_d;
  logic               out_valid_q, out_valid_d;
  logic [31:0]        out_data_q, out_data_d;
  logic               out_last_q, out_last_d;
  logic [CNT_W-1:0]   word_cnt_q, word_cnt_d;
  logic               seed_err_q, seed_err_d;

  logic               in_xfer;
  logic               out_xfer;
  logic               seed_accept;
  logic [31:0]        keystream;

  // Accept input only while ACTIVE and the output register is free or draining.
  assign in_ready    = (state_q == StActive) && (!out_valid_q || out_ready);
  assign in_xfer     = in_valid && in_ready;
  assign out_xfer    = out_valid_q && out_ready;
  assign seed_accept = seed_load && (state_q == StIdle);

  lfsr32_galois #(
    .POLY (POLY)
  ) u_lfsr (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .load_i  (seed_accept),
    .seed_i  (fix_seed(seed)),
    .step_i  (in_xfer),
    .state_o (keystream)
  );

  // Next-state for control FSM, output register, counter and error flag.
  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    word_cnt_d  = word_cnt_q;
    seed_err_d  = seed_err_q;

    unique case (state_q)
      StIdle: begin
        if (seed_load) begin
          state_d    = StActive;
          word_cnt_d = '0;
        end
      end
      StActive: begin
        if (in_xfer && in_last) begin
          state_d = StDrain;
        end
      end
      StDrain: begin
        if (out_xfer && out_last_q) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    // A seed outside IDLE is dropped but remembered until reset.
    if (seed_load && (state_q != StIdle)) begin
      seed_err_d = 1'b1;
    end

    if (out_xfer) begin
      out_valid_d = 1'b0;
    end

    // A simultaneous input transfer refills the register, giving full throughput.
    if (in_xfer) begin
      out_valid_d = 1'b1;
      out_data_d  = in_data ^ keystream;
      out_last_d  = in_last;
      if (word_cnt_q != {CNT_W{1'b1}}) begin
        word_cnt_d = word_cnt_q + 1'b1;
      end
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      out_valid_q <= 1'b0;
      out_data_q  <= 32'h0;
      out_last_q  <= 1'b0;
      word_cnt_q  <= '0;
      seed_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      word_cnt_q  <= word_cnt_d;
      seed_err_q  <= seed_err_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;
  assign word_cnt  = word_cnt_q;
  assign seed_err  = seed_err_q;

endmodule

// File: tb/tb_xor_descrambler32.sv
// Directed and table-driven bench for xor_descrambler32.
module tb_xor_descrambler32;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        seed_load = 1'b0;
  logic [31:0] seed = 32'h0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_data = 32'h0;
  logic        in_last = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_data;
  logic        out_last;
  logic [15:0] word_cnt;
  logic        seed_err;

  // Narrow-counter instance sharing all inputs, used to observe saturation.
  logic        s_in_ready, s_out_valid, s_out_last, s_seed_err;
  logic [31:0] s_out_data;
  logic [1:0]  s_word_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] pkt_in[$];
  logic [31:0] pkt_out[$];
  logic        pkt_last[$];

  typedef struct packed {
    logic [31:0]      seed;
    logic [2:0][31:0] din;
    logic [2:0][31:0] dout;
  } vec_t;

  vec_t vecs[3];

  always #5 clk = ~clk;

  xor_descrambler32 dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .seed_load (seed_load),
    .seed      (seed),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .word_cnt  (word_cnt),
    .seed_err  (seed_err)
  );

  xor_descrambler32 #(
    .CNT_W (2)
  ) dut_s (
    .clk       (clk),
    .rst_n     (rst_n),
    .seed_load (seed_load),
    .seed      (seed),
    .in_valid  (in_valid),
    .in_ready  (s_in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (s_out_valid),
    .out_ready (out_ready),
    .out_data  (s_out_data),
    .out_last  (s_out_last),
    .word_cnt  (s_word_cnt),
    .seed_err  (s_seed_err)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] ks_step(input logic [31:0] l);
    return (l >> 1) ^ (l[0] ? 32'h80200003 : 32'h0);
  endfunction

  // Pulse seed_load in IDLE and confirm the block is ACTIVE with a cleared count.
  task automatic load_seed(input logic [31:0] s);
    @(posedge clk); #1;
    check("idle_in_ready", 32'(in_ready), 32'd0);
    seed      = s;
    seed_load = 1'b1;
    @(posedge clk); #1;
    seed_load = 1'b0;
    check("cnt_cleared_on_load", 32'(word_cnt), 32'd0);
    check("ready_after_load", 32'(in_ready), 32'd1);
  endtask

  // Stream pkt_in through the block, collecting outputs into pkt_out/pkt_last.
  task automatic run_pkt(input bit rnd, input int stall_at, input int stall_len,
                         input int sl_at, input int budget);
    int idx = 0;
    int cyc = 0;
    int n   = pkt_in.size();
    pkt_out.delete();
    pkt_last.delete();
    while (pkt_out.size() < n && cyc < budget) begin
      @(posedge clk); #1;
      in_valid  = (idx < n) && (rnd ? ($urandom_range(0, 1) == 1) : 1'b1);
      in_data   = (idx < n) ? pkt_in[idx] : 32'h0;
      in_last   = (idx == n - 1);
      out_ready = rnd ? ($urandom_range(0, 1) == 1)
                      : !(cyc >= stall_at && cyc < stall_at + stall_len);
      seed_load = (cyc == sl_at);
      seed      = 32'hDEADBEEF;
      @(negedge clk);
      if (in_valid && in_ready) idx++;
      if (out_valid && out_ready) begin
        pkt_out.push_back(out_data);
        pkt_last.push_back(out_last);
      end
      cyc++;
    end
    check("pkt_word_count_in_budget", 32'(pkt_out.size()), 32'(n));
    @(posedge clk); #1;
    in_valid  = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b0;
    seed_load = 1'b0;
  endtask

  task automatic check_req035_outputs(input string tag);
    check({tag, "_w0"}, pkt_out.size() > 0 ? pkt_out[0] : 32'hX, 32'hFFFFFFFE);
    check({tag, "_w1"}, pkt_out.size() > 1 ? pkt_out[1] : 32'hX, 32'h80200003);
    check({tag, "_w2"}, pkt_out.size() > 2 ? pkt_out[2] : 32'hX, 32'hD204567A);
    check({tag, "_cnt"}, 32'(word_cnt), 32'd3);
  endtask

  initial begin
    vecs[0] = '{seed: 32'h00000001,
                din:  {32'h12345678, 32'h00000000, 32'hFFFFFFFF},
                dout: {32'hD204567A, 32'h80200003, 32'hFFFFFFFE}};
    vecs[1] = '{seed: 32'h00000000,
                din:  {32'h12345678, 32'h00000000, 32'hFFFFFFFF},
                dout: {32'hD204567A, 32'h80200003, 32'hFFFFFFFE}};
    vecs[2] = '{seed: 32'h80000000,
                din:  {32'hFFFFFFFF, 32'h00000000, 32'h00000000},
                dout: {32'hDFFFFFFF, 32'h40000000, 32'h80000000}};

    // Reset state.
    #12;
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", out_data, 32'd0);
    check("rst_out_last", 32'(out_last), 32'd0);
    check("rst_word_cnt", 32'(word_cnt), 32'd0);
    check("rst_seed_err", 32'(seed_err), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Table: three-word packets with full-rate handshakes.
    for (int v = 0; v < 3; v++) begin
      load_seed(vecs[v].seed);
      pkt_in.delete();
      for (int w = 0; w < 3; w++) pkt_in.push_back(vecs[v].din[w]);
      run_pkt(1'b0, 1000, 0, -1, 40);
      for (int w = 0; w < 3; w++) begin
        check($sformatf("vec%0d_w%0d", v, w),
              pkt_out.size() > w ? pkt_out[w] : 32'hX, vecs[v].dout[w]);
      end
      check($sformatf("vec%0d_last_pattern", v),
            pkt_last.size() == 3 ? 32'({pkt_last[2], pkt_last[1], pkt_last[0]}) : 32'hX,
            32'd4);
      check($sformatf("vec%0d_cnt", v), 32'(word_cnt), 32'd3);
      check($sformatf("vec%0d_idle_ready", v), 32'(in_ready), 32'd0);
      check($sformatf("vec%0d_idle_valid", v), 32'(out_valid), 32'd0);
    end
    check("no_seed_err_yet", 32'(seed_err), 32'd0);

    // Back-pressure: four stalled cycles with a word held in the output register.
    load_seed(32'h1);
    in_valid = 1'b1; in_data = 32'hFFFFFFFF; in_last = 1'b0; out_ready = 1'b0;
    @(posedge clk); #1;
    in_data = 32'h00000000;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("stall_in_ready", 32'(in_ready), 32'd0);
      check("stall_out_valid", 32'(out_valid), 32'd1);
      check("stall_out_data", out_data, 32'hFFFFFFFE);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(negedge clk);
    check("resume_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_data = 32'h12345678; in_last = 1'b1;
    @(negedge clk);
    check("resume_w1", out_data, 32'h80200003);
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0;
    @(negedge clk);
    check("resume_w2", out_data, 32'hD204567A);
    check("resume_w2_last", 32'(out_last), 32'd1);
    check("drain_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("resume_idle_valid", 32'(out_valid), 32'd0);
    check("resume_cnt", 32'(word_cnt), 32'd3);

    // Stray seed_load mid-packet: flagged, keystream untouched.
    load_seed(32'h1);
    pkt_in.delete();
    pkt_in.push_back(32'hFFFFFFFF); pkt_in.push_back(32'h0); pkt_in.push_back(32'h12345678);
    run_pkt(1'b0, 1000, 0, 2, 40);
    check_req035_outputs("seederr");
    check("seed_err_set", 32'(seed_err), 32'd1);
    repeat (2) @(posedge clk);
    #1 check("seed_err_sticky", 32'(seed_err), 32'd1);

    // Reset while a word is pending.
    load_seed(32'h1);
    in_valid = 1'b1; in_data = 32'hFFFFFFFF; out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("pre_rst_out_valid", 32'(out_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_out_data", out_data, 32'd0);
    check("midrst_in_ready", 32'(in_ready), 32'd0);
    check("midrst_seed_err", 32'(seed_err), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    in_valid = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("postrst_in_ready", 32'(in_ready), 32'd0);
      check("postrst_out_valid", 32'(out_valid), 32'd0);
    end
    in_valid = 1'b0; out_ready = 1'b0;

    // Seed accepted on the first edge after reset release.
    rst_n = 1'b0;
    #3;
    @(negedge clk);
    rst_n = 1'b1; seed = 32'h1; seed_load = 1'b1;
    @(posedge clk); #1;
    seed_load = 1'b0;
    check("first_edge_load_ready", 32'(in_ready), 32'd1);
    pkt_in.delete();
    pkt_in.push_back(32'hFFFFFFFF); pkt_in.push_back(32'h0); pkt_in.push_back(32'h12345678);
    run_pkt(1'b0, 1000, 0, -1, 40);
    check_req035_outputs("postrst");

    // 1000-word random packet scrambled by a bench model, random handshakes.
    begin
      logic [31:0] pt[$];
      logic [31:0] lf;
      logic [31:0] rs;
      int errs = 0;
      int lasts = 0;
      rs = $urandom() | 32'h1;
      lf = rs;
      pkt_in.delete();
      for (int i = 0; i < 1000; i++) begin
        pt.push_back($urandom());
        pkt_in.push_back(pt[i] ^ lf);
        lf = ks_step(lf);
      end
      load_seed(rs);
      run_pkt(1'b1, 0, 0, -1, 20000);
      for (int i = 0; i < pkt_out.size(); i++) begin
        if (pkt_out[i] !== pt[i]) errs++;
        if (pkt_last[i]) lasts++;
      end
      check("rand_data_errors", 32'(errs), 32'd0);
      check("rand_last_count", 32'(lasts), 32'd1);
      check("rand_last_on_final",
            pkt_last.size() == 1000 ? 32'(pkt_last[999]) : 32'hX, 32'd1);
      check("rand_word_cnt", 32'(word_cnt), 32'd1000);
      check("rand_word_cnt_saturated", 32'(s_word_cnt), 32'd3);
      check("rand_idle_ready", 32'(in_ready), 32'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/xor_descrambler32.md
XOR_DESCRAMBLER32 -- requirements
Module: xor_descrambler32

Interface
REQ-001 SHALL have parameter POLY, default 32'h80200003, Galois LFSR feedback mask (x^32+x^22+x^2+x+1).
REQ-002 SHALL have parameter CNT_W, default 16, width of word counter.
REQ-003 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset; asynchronous, active-low.
REQ-005 SHALL have port seed_load  input  1  load-seed strobe.
REQ-006 SHALL have port seed  input  32  keystream seed.
REQ-007 SHALL have port in_valid  input  1  scrambled word present.
REQ-008 SHALL have port in_ready  output  1  block accepts input word.
REQ-009 SHALL have port in_data  input  32  scrambled word.
REQ-010 SHALL have port in_last  input  1  final word of packet.
REQ-011 SHALL have port out_valid  output  1  descrambled word present.
REQ-012 SHALL have port out_ready  input  1  downstream accepts word.
REQ-013 SHALL have port out_data  output  32  descrambled word.
REQ-014 SHALL have port out_last  output  1  final word of packet.
REQ-015 SHALL have port word_cnt  output  CNT_W  words accepted in current packet.
REQ-016 SHALL have port seed_err  output  1  sticky: seed_load seen outside IDLE.

Function
REQ-017 SHALL implement states IDLE, ACTIVE, DRAIN.
REQ-018 IDLE: in_ready=0; seed_load -> state register = seed (0 replaced by 32'h00000001), word_cnt=0, go ACTIVE next cycle.
REQ-019 ACTIVE: in_ready = !out_valid || out_ready (single output register, full throughput, no bubbles).
REQ-020 Input transfer = in_valid && in_ready; on transfer: out_data <= in_data XOR lfsr, out_last <= in_last, out_valid <= 1, word_cnt += 1.
REQ-021 Latency SHALL be exactly one cycle from input transfer to out_valid.
REQ-022 LFSR step on each transfer only: next = (lfsr >> 1) XOR (lfsr[0] ? POLY : 0); no advance without transfer.
REQ-023 Output transfer = out_valid && out_ready; clears out_valid unless a simultaneous input transfer reloads it.
REQ-024 out_valid, out_data, out_last SHALL hold stable while out_valid && !out_ready.
REQ-025 Input transfer with in_last=1 -> DRAIN; in_ready=0 in DRAIN.
REQ-026 DRAIN: output transfer of the out_last word -> IDLE; new packet requires new seed_load.
REQ-027 seed_load in ACTIVE or DRAIN SHALL be ignored and set seed_err; seed_err cleared only by reset.
REQ-028 word_cnt SHALL saturate at all-ones, not wrap; holds value through DRAIN and IDLE until next seed_load.
REQ-029 Data path is bitwise XOR, width-exact, no carry; identical keystream makes block its own inverse.

Reset
REQ-030 rst_n low SHALL asynchronously force: state=IDLE, lfsr=32'h00000001, out_valid=0, out_data=0, out_last=0, word_cnt=0, seed_err=0, in_ready=0.
REQ-031 Reset mid-packet SHALL discard pending output word; no partial output after release.
REQ-032 First seed_load accepted on first rising edge after rst_n deasserts.

Structure
REQ-033 Shared package SHALL hold state encoding (IDLE=2'd0, ACTIVE=2'd1, DRAIN=2'd2), default POLY and the zero-seed substitute constant.
REQ-034 SHALL instantiate one sub-module lfsr32_galois (seed load, step enable, POLY parameter, 32-bit state out).

Verification
REQ-035 seed=1, inputs 0xFFFFFFFF,0x00000000,0x12345678(last), out_ready=1 -> outputs 0xFFFFFFFE,0x80200003,0xD204567A, out_last on third, word_cnt=3, IDLE after.
REQ-036 seed=0 -> identical outputs to seed=1 case.
REQ-037 out_ready=0 for 4 cycles mid-packet -> in_ready=0, out_data held, LFSR unchanged; resume gives same sequence as REQ-035.
REQ-038 seed_load pulse in ACTIVE -> seed_err=1, keystream unaffected, outputs still match REQ-035.
REQ-039 rst_n low while out_valid=1 in ACTIVE -> out_valid=0 immediately, state IDLE, in_ready=0 until next seed_load.
REQ-040 Random 1000-word packet through scrambler model and this block, random valid/ready -> output equals original plaintext, word_cnt=1000.
